// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write
//   ports (port 1 wins on a same-address collision), x0 hardwired to zero.
// Latency: reads are combinational. Writes commit on the rising edge.
//   Optional write-through forwarding is enabled with macro REGFILE_BYPASS_EN.
// Backpressure: none on reads or writes. After reset, busy stays high for the
//   NREGS-1 cycle clear sweep. While busy, reads return 0 and writes are dropped.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rd_addr / rd_data     NRD packed read lanes (lane k at [k*AW +: AW] / [k*XLEN +: XLEN])
//   we0/wa0/wd0           write port 0 (ALU writeback)
//   we1/wa1/wd1           write port 1 (load writeback, higher priority)
//   busy                  high while in reset or during the clear sweep
module reg_file_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  input  logic                  we0,
  input  logic [AW-1:0]         wa0,
  input  logic [XLEN-1:0]       wd0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa1,
  input  logic [XLEN-1:0]       wd1,
  output logic                  busy
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] regs [NREGS];

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (rst) begin
      // x0 is never stored, so the sweep starts at index 1.
      state_d   = CLEAR;
      clr_idx_d = IDX_ONE;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_idx_d = clr_idx_q + IDX_ONE;
          if (clr_idx_q == LAST_IDX) begin
            state_d = READY;
          end
        end
        READY:   state_d = READY;
        default: state_d = CLEAR;
      endcase
    end
  end

  assign busy = (state_q == CLEAR);

  // ---------------------------------------------------------------------------
  // Storage. Entry 0 is never written; reads of address 0 are forced to zero.
  // Storage is left untouched on edges where rst is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        regs[clr_idx_q] <= '0;
      end else begin
        // Port 1 is assigned last so it wins a same-address collision.
        if (we0 && (wa0 != '0)) regs[wa0] <= wd0;
        if (we1 && (wa1 != '0)) regs[wa1] <= wd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read lanes
  // ---------------------------------------------------------------------------
  logic [AW-1:0]   ra;
  logic [XLEN-1:0] lane;

  always_comb begin
    rd_data = '0;
    ra      = '0;
    lane    = '0;
    for (int k = 0; k < NRD; k++) begin
      ra   = rd_addr[k*AW +: AW];
      lane = '0;
      if ((state_q == READY) && (ra != '0)) begin
        lane = regs[ra];
`ifdef REGFILE_BYPASS_EN
        // Forward only writes that will actually commit this edge; port 1
        // is checked last to mirror the write priority.
        if (!rst) begin
          if (we0 && (wa0 == ra)) lane = wd0;
          if (we1 && (wa1 == ra)) lane = wd1;
        end
`endif
      end
      rd_data[k*XLEN +: XLEN] = lane;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                we0, we1;
  logic [AW-1:0]       wa0, wa1;
  logic [XLEN-1:0]     wd0, wd1;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .we0     (we0),
    .wa0     (wa0),
    .wd0     (wd0),
    .we1     (we1),
    .wa1     (wa1),
    .wd1     (wd1),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            we0;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic            we1;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    logic [XLEN-1:0] e0;
    logic [XLEN-1:0] e1;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle_writes();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
  endtask

  // Count cycles until busy drops, bounded so a stuck FSM cannot hang the run.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < NREGS; a++) begin
      set_rd(AW'(a), AW'(NREGS - 1 - a));
      #1;
      check(name, rd_data[XLEN-1:0], '0);
      check(name, rd_data[2*XLEN-1:XLEN], '0);
    end
  endtask

  int cnt;
  logic [XLEN-1:0] exp_byp;

  initial begin
    rst = 1'b1;
    idle_writes();
    set_rd('0, '0);

    // ---------------- Reset and sweep, writes attempted mid-sweep -----------
    repeat (3) @(posedge clk);
    #1;
    check("busy_in_reset", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000_0077;
    we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h0000_0099;
    set_rd(5'd4, 5'd2);
    #1;
    check("busy_read_lane0", rd_data[XLEN-1:0], '0);
    check("busy_read_lane1", rd_data[2*XLEN-1:XLEN], '0);
    count_busy(cnt);
    idle_writes();
    check("sweep_cycles", 32'(cnt), 32'd31);
    check("busy_after_sweep", {31'b0, busy}, 32'd0);
    check_all_zero("sweep_zero");

    // ---------------- Table-driven write/read vectors ------------------------
    // Each row: drive writes and read addresses, compare pre-edge read data,
    // then the edge commits the writes. Rows never read an address being
    // written in the same row, so expectations hold with or without bypass.
    tbl[0]  = '{1'b1, 5'd5,  32'h0000_0020, 1'b0, 5'd0,  32'h0,          5'd6,  5'd4,  32'h0,          32'h0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          5'd5,  5'd6,  32'h0000_0020, 32'h0};
    tbl[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,          5'd5,  5'd0,  32'h0000_0020, 32'h0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          5'd0,  5'd0,  32'h0,          32'h0};
    tbl[4]  = '{1'b1, 5'd7,  32'h1111_1111, 1'b1, 5'd7,  32'h2222_2222, 5'd5,  5'd0,  32'h0000_0020, 32'h0};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          5'd7,  5'd0,  32'h2222_2222, 32'h0};
    tbl[6]  = '{1'b1, 5'd7,  32'h1111_1111, 1'b1, 5'd8,  32'h2222_2222, 5'd5,  5'd31, 32'h0000_0020, 32'h0};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          5'd7,  5'd8,  32'h1111_1111, 32'h2222_2222};
    tbl[8]  = '{1'b1, 5'd1,  32'h1234_5678, 1'b1, 5'd31, 32'hDEAD_BEEF, 5'd2,  5'd0,  32'h0,          32'h0};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          5'd31, 5'd1,  32'hDEAD_BEEF, 32'h1234_5678};
    tbl[10] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd0,  32'hCAFE_F00D, 5'd31, 5'd1,  32'hDEAD_BEEF, 32'h1234_5678};
    tbl[11] = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          5'd0,  5'd0,  32'h0,          32'h0};

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
      set_rd(tbl[i].ra0, tbl[i].ra1);
      #1;
      check($sformatf("vec%0d_lane0", i), rd_data[XLEN-1:0], tbl[i].e0);
      check($sformatf("vec%0d_lane1", i), rd_data[2*XLEN-1:XLEN], tbl[i].e1);
    end

    // ---------------- Bypass / same-cycle visibility -------------------------
    @(negedge clk);
    idle_writes();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_00A0;
    set_rd(5'd0, 5'd0);
    @(negedge clk);
    idle_writes();
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0000_00B0;
    set_rd(5'd3, 5'd3);
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h0000_00B0;
`else
    exp_byp = 32'h0000_00A0;
`endif
    #1;
    check("bypass_same_cycle", rd_data[XLEN-1:0], exp_byp);
    @(negedge clk);
    idle_writes();
    #1;
    check("bypass_next_cycle", rd_data[XLEN-1:0], 32'h0000_00B0);

    // Both ports target reg3: port 1 data must be the one seen / stored.
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_00C0;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0000_00D0;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h0000_00D0;
`else
    exp_byp = 32'h0000_00B0;
`endif
    #1;
    check("bypass_both_ports", rd_data[2*XLEN-1:XLEN], exp_byp);
    @(negedge clk);
    idle_writes();
    #1;
    check("both_ports_stored", rd_data[2*XLEN-1:XLEN], 32'h0000_00D0);

    // ---------------- Reset mid-sweep ----------------------------------------
    for (int a = 1; a < NREGS; a++) begin
      @(negedge clk);
      we0 = 1'b1; wa0 = AW'(a); wd0 = 32'h5A5A_5A5A;
    end
    @(negedge clk);
    idle_writes();
    set_rd(5'd10, 5'd31);
    #1;
    check("preload_reg10", rd_data[XLEN-1:0], 32'h5A5A_5A5A);
    check("preload_reg31", rd_data[2*XLEN-1:XLEN], 32'h5A5A_5A5A);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(posedge clk);   // sweep now sits at clr_idx = 10
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("busy_mid_reset", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    count_busy(cnt);
    check("restart_sweep_cycles", 32'(cnt), 32'd31);
    check_all_zero("restart_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file, successor to the core's 2R1W file. Provides NRD combinational read ports, two write ports with fixed priority, and x0 hardwired to zero. After reset, a hardware sweep clears every register, so the state is deterministic without simulation-only preloads. Sits in the decode/writeback stage of the RISC-V core and is shared by the ALU and load writeback paths.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=4)
AW, 5, address width; must equal log2(NREGS)
NRD, 2, number of read ports (1..4)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
rd_addr  input  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  output  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
we0  input  1  write enable, port 0 (ALU writeback)
wa0  input  AW  write address, port 0
wd0  input  XLEN  write data, port 0
we1  input  1  write enable, port 1 (load writeback)
wa1  input  AW  write address, port 1
wd1  input  XLEN  write data, port 1
busy  output  1  high while reset or the clear sweep is in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- FSM states are CLEAR and READY, with a clear index clr_idx of AW bits.
- While rst=1 at an edge: state <= CLEAR, clr_idx <= 1. Storage is not otherwise touched during reset.
- CLEAR, rst=0: each edge writes 0 to reg[clr_idx] and increments clr_idx.
- CLEAR, clr_idx == NREGS-1: after that write, state <= READY. The sweep takes NREGS-1 cycles after rst falls.
- READY: remains READY until the next rst.
- busy = 1 when state == CLEAR, including during rst. busy = 0 when READY.
- busy is combinational from state; rst itself forces state to CLEAR on the next edge.
- busy reads: while busy=1, every rd_data lane reads 0.
- busy writes: while busy=1, we0/we1 are ignored.
- Reset mid-sweep: rst re-asserted during CLEAR restarts the sweep at clr_idx=1.
- Register x0: reads of address 0 always return 0. Writes to address 0 are discarded on both ports.
- Writes (READY only): on a rising edge, if weN=1 and waN!=0, reg[waN] <= wdN.
- Same-address writes: we0=we1=1 with wa0==wa1!=0 -> port 1 (load) wins, and wd0 is dropped.
- Distinct-address writes: both are committed in the same cycle.
- Reads: combinational from rd_addr, no latency. Returns the stored value unless bypassed (see Optional Feature).
- Addresses: all values of an AW-bit address are legal (NREGS = 2^AW), so there is no out-of-range case.
- Data width: data is XLEN bits unmodified; there is no sign or width conversion.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. In READY, if rd_addr[k] != 0 matches an enabled write address in the same cycle, rd_data[k] returns that write data combinationally.
- Defined, both ports match: port 1 data is forwarded, matching write priority.
- Defined, during busy: no bypass; lanes still read 0.
- Not defined: reads return pre-edge storage contents. A same-cycle write becomes visible the cycle after the edge, and the pipeline must cover the hazard externally.

Test Plan:
1. Reset and sweep: hold rst 3 cycles, release -> busy=1 for exactly 31 cycles, then 0. All 32 registers read 0x00000000, and writes attempted mid-sweep are not retained.
2. Basic write/read: READY, we0=1, wa0=5, wd0=0x00000020 -> next cycle rd_addr port0=5 reads 0x00000020. Port1 reading 6 returns 0.
3. x0 discard: we0=1, wa0=0, wd0=0xFFFFFFFF -> read address 0 returns 0x00000000 on all lanes.
4. Write conflict: we0=we1=1, wa0=wa1=7, wd0=0x11111111, wd1=0x22222222 -> reg7 reads 0x22222222. Repeat with wa1=8 -> reg7=0x11111111 and reg8=0x22222222.
5. Bypass: write reg3=0xA0 (same-cycle read of reg3 is a separate check, below). Then, in one cycle, we1=1, wa1=3, wd1=0xB0 with rd_addr port0=3:
   - REGFILE_BYPASS_EN defined -> rd_data0=0xB0 in that cycle.
   - REGFILE_BYPASS_EN undefined -> rd_data0=0xA0 in that cycle, 0xB0 in the next.
6. Reset mid-sweep: assert rst 1 cycle when clr_idx=10 after registers were loaded with 0x5A5A5A5A -> sweep restarts, busy lasts another 31 cycles, and all registers end at 0.
